// File: rtl/div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_request_sequencer
// Purpose  : In-order request front end for the iterative divider. Queues
//            tagged requests, issues them one at a time, bypasses x/0 locally
//            and returns results in order over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module div_request_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_go,
    output logic [WIDTH-1:0] div_left,
    output logic [WIDTH-1:0] div_right,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_by_zero,
    output logic             busy
);

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]  c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_fifo_left  [DEPTH];
    logic [WIDTH-1:0]   r_fifo_right [DEPTH];
    logic [TAG_W-1:0]   r_fifo_tag   [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic               r_div_go;
    logic [WIDTH-1:0]   r_div_left;
    logic [WIDTH-1:0]   r_div_right;
    logic [TAG_W-1:0]   r_tag_hold;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_quotient;
    logic [WIDTH-1:0]   r_out_remainder;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_div_by_zero;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_launch;
    logic               w_bypass;
    logic [WIDTH-1:0]   w_head_left;
    logic [WIDTH-1:0]   w_head_right;
    logic [TAG_W-1:0]   w_head_tag;

    assign w_full       = (r_count == c_FULL_CNT);
    assign w_empty      = (r_count == '0);
    // Gate with reset so the source sees ready low while reset is asserted.
    assign in_ready     = reset && !w_full;
    assign w_push       = in_valid && in_ready;
    assign w_head_left  = r_fifo_left[r_rd_ptr];
    assign w_head_right = r_fifo_right[r_rd_ptr];
    assign w_head_tag   = r_fifo_tag[r_rd_ptr];
    assign w_bypass     = (w_head_right == '0);
    // Waiting for out_valid to drop keeps a single result outstanding.
    assign w_launch     = (r_state == ST_IDLE) && !w_empty && !r_out_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_left[r_wr_ptr]  <= in_left;
            r_fifo_right[r_wr_ptr] <= in_right;
            r_fifo_tag[r_wr_ptr]   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_launch) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_launch) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_launch) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_launch && !w_bypass) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (div_done) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_go    <= 1'b0;
            r_div_left  <= '0;
            r_div_right <= '0;
            r_tag_hold  <= '0;
        end else begin
            r_div_go <= w_launch && !w_bypass;
            if (w_launch && !w_bypass) begin
                r_div_left  <= w_head_left;
                r_div_right <= w_head_right;
                r_tag_hold  <= w_head_tag;
            end
        end
    end

    // Loads never coincide with a handshake: both load paths require out_valid=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid       <= 1'b0;
            r_out_quotient    <= '0;
            r_out_remainder   <= '0;
            r_out_tag         <= '0;
            r_out_div_by_zero <= 1'b0;
        end else if (w_launch && w_bypass) begin
            r_out_valid       <= 1'b1;
            r_out_quotient    <= '1;
            r_out_remainder   <= w_head_left;
            r_out_tag         <= w_head_tag;
            r_out_div_by_zero <= 1'b1;
        end else if ((r_state == ST_WAIT) && div_done) begin
            r_out_valid       <= 1'b1;
            r_out_quotient    <= div_quotient;
            r_out_remainder   <= div_remainder;
            r_out_tag         <= r_tag_hold;
            r_out_div_by_zero <= 1'b0;
        end else if (r_out_valid && out_ready) begin
            r_out_valid       <= 1'b0;
        end
    end

    assign div_go          = r_div_go;
    assign div_left        = r_div_left;
    assign div_right       = r_div_right;
    assign out_valid       = r_out_valid;
    assign out_quotient    = r_out_quotient;
    assign out_remainder   = r_out_remainder;
    assign out_tag         = r_out_tag;
    assign out_div_by_zero = r_out_div_by_zero;
    assign busy            = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_request_sequencer
// Purpose  : Directed self-checking bench with a behavioural divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_request_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_left = '0;
    logic [3:0] in_right = '0;
    logic [1:0] in_tag = '0;
    logic       div_go;
    logic [3:0] div_left;
    logic [3:0] div_right;
    logic       div_done = 1'b0;
    logic [3:0] div_quotient = '0;
    logic [3:0] div_remainder = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_quotient;
    logic [3:0] out_remainder;
    logic [1:0] out_tag;
    logic       out_div_by_zero;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_request_sequencer #(.WIDTH(4), .DEPTH(4), .TAG_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_left         (in_left),
        .in_right        (in_right),
        .in_tag          (in_tag),
        .div_go          (div_go),
        .div_left        (div_left),
        .div_right       (div_right),
        .div_done        (div_done),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .out_remainder   (out_remainder),
        .out_tag         (out_tag),
        .out_div_by_zero (out_div_by_zero),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Divider model: not reset, so an in-flight operation yields a stale done.
    logic       m_active = 1'b0;
    logic [3:0] m_cnt = '0;
    logic [3:0] m_a = '0;
    logic [3:0] m_b = '0;
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_go) begin
            m_active <= 1'b1;
            m_a      <= div_left;
            m_b      <= div_right;
            m_cnt    <= (div_left == 4'd0) ? 4'd2 : 4'd6;
        end else if (m_active) begin
            if (m_cnt == 4'd1) begin
                div_done      <= 1'b1;
                div_quotient  <= (m_b == 4'd0) ? 4'hF : m_a / m_b;
                div_remainder <= (m_b == 4'd0) ? m_a  : m_a % m_b;
                m_active      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] l, input logic [3:0] r, input logic [1:0] t);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        in_tag   = t;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_fields(input string tag, input logic [3:0] q, input logic [3:0] r,
                                input logic [1:0] t, input logic z);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_q"}, out_quotient, q);
        check({tag, "_r"}, out_remainder, r);
        check({tag, "_tag"}, out_tag, t);
        check({tag, "_dbz"}, out_div_by_zero, z);
    endtask

    // Waits for out_valid, checks it, then moves past the handshake edge.
    task automatic wait_result(input string tag, input logic [3:0] q, input logic [3:0] r,
                               input logic [1:0] t, input logic z);
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_fields(tag, q, r, t, z);
        @(negedge clk);
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] exp_r[$];
    logic [1:0] exp_t[$];
    logic       exp_z[$];

    initial begin
        bit stale_seen;
        int sent;
        int got;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_div_go", div_go, 0);
        check("rst_busy", busy, 0);
        check("rst_out_q", out_quotient, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // 13/3 through the divider, one-cycle go pulse
        out_ready = 1'b1;
        push(4'd13, 4'd3, 2'd1);
        @(negedge clk);
        check("go_high", div_go, 1);
        check("go_left", div_left, 13);
        check("go_right", div_right, 3);
        check("go_busy", busy, 1);
        @(negedge clk);
        check("go_low", div_go, 0);
        check("hold_left", div_left, 13);
        wait_result("r13_3", 4'd4, 4'd1, 2'd1, 1'b0);

        // 7/0 bypass, result one edge after acceptance
        push(4'd7, 4'd0, 2'd2);
        @(negedge clk);
        check("byp_no_go", div_go, 0);
        check_fields("r7_0", 4'hF, 4'd7, 2'd2, 1'b1);
        @(negedge clk);
        check("byp_drop", out_valid, 0);

        // Zero dividend, then 15/1, in order
        push(4'd0, 4'd5, 2'd0);
        push(4'd15, 4'd1, 2'd3);
        wait_result("r0_5", 4'd0, 4'd0, 2'd0, 1'b0);
        wait_result("r15_1", 4'd15, 4'd0, 2'd3, 1'b0);

        // Backpressure: first result held, four queued, FIFO full
        out_ready = 1'b0;
        push(4'd9, 4'd2, 2'd0);
        push(4'd8, 4'd0, 2'd1);
        push(4'd6, 4'd4, 2'd2);
        push(4'd3, 4'd3, 2'd3);
        push(4'd14, 4'd5, 2'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_left  = 4'd1;
        in_right = 4'd1;
        in_tag   = 2'd1;
        check("full_not_ready", in_ready, 0);
        @(negedge clk);
        check("full_still_not_ready", in_ready, 0);
        in_valid = 1'b0;
        for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
        check_fields("held_a", 4'd4, 4'd1, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_fields("held_b", 4'd4, 4'd1, 2'd0, 1'b0);
        check("held_busy", busy, 1);
        out_ready = 1'b1;
        wait_result("bp0", 4'd4, 4'd1, 2'd0, 1'b0);
        wait_result("bp1", 4'hF, 4'd8, 2'd1, 1'b1);
        wait_result("bp2", 4'd1, 4'd2, 2'd2, 1'b0);
        wait_result("bp3", 4'd1, 4'd0, 2'd3, 1'b0);
        wait_result("bp4", 4'd2, 4'd4, 2'd0, 1'b0);
        check("bp_empty_busy", busy, 0);

        // Reset during WAIT; stale done from the model must be ignored
        push(4'd12, 4'd5, 2'd2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_div_go", div_go, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_left", div_left, 0);
        check("mid_rst_right", div_right, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stale_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid || busy || div_go) stale_seen = 1'b1;
        end
        check("stale_done_ignored", stale_seen, 0);
        push(4'd10, 4'd3, 2'd1);
        wait_result("r10_3", 4'd3, 4'd1, 2'd1, 1'b0);

        // Random back-to-back traffic with random backpressure
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 3000 && got < 24; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 24) && ($urandom_range(0, 3) != 0);
            in_left   = 4'($urandom_range(0, 15));
            in_right  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            in_tag    = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back((in_right == 4'd0) ? 4'hF : in_left / in_right);
                exp_r.push_back((in_right == 4'd0) ? in_left : in_left % in_right);
                exp_t.push_back(in_tag);
                exp_z.push_back(in_right == 4'd0);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", 1, 0);
                end else begin
                    check("rand_q", out_quotient, exp_q.pop_front());
                    check("rand_r", out_remainder, exp_r.pop_front());
                    check("rand_tag", out_tag, exp_t.pop_front());
                    check("rand_dbz", out_div_by_zero, exp_z.pop_front());
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_all_results", got, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/div_request_sequencer.md
Name: div_request_sequencer

Overview:
- Front-end stage that sits directly upstream of the iterative pipelined divider and drives its go/left/right/done interface.
- Accepts a stream of tagged divide requests over valid/ready and buffers them in a small in-order FIFO.
- Issues one request at a time to the divider, short-circuits divide-by-zero locally, and presents results in order over valid/ready with the tag preserved.

Parameters:
- WIDTH, 4, operand/result width; must match the divider's WIDTH.
- DEPTH, 4, request FIFO entries; power of two, >= 2.
- TAG_W, 2, width of the opaque request tag carried to the result.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_left  in  WIDTH  dividend.
- in_right  in  WIDTH  divisor.
- in_tag  in  TAG_W  request tag.
- div_go  out  1  start pulse to the divider; registered.
- div_left  out  WIDTH  dividend to the divider; registered.
- div_right  out  WIDTH  divisor to the divider; registered.
- div_done  in  1  divider completion pulse.
- div_quotient  in  WIDTH  divider quotient; valid while div_done=1.
- div_remainder  in  WIDTH  divider remainder; valid while div_done=1.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_quotient  out  WIDTH  result quotient.
- out_remainder  out  WIDTH  result remainder.
- out_tag  out  TAG_W  tag of the result.
- out_div_by_zero  out  1  result came from the divide-by-zero bypass.
- busy  out  1  1 when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset values (while reset=0): FIFO empty, state IDLE, all outputs 0 (in_ready=0 during reset).
- in_ready = !fifo_full. No pass-through when full, even if a pop occurs the same cycle. Simultaneous push and pop when not full: count unchanged, order preserved.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, launch condition: FIFO non-empty && out_valid=0. When met, pop the head at the edge.
  - Head right==0 (bypass): stay IDLE. Load output registers with quotient={WIDTH{1'b1}}, remainder=head left, tag, out_div_by_zero=1. out_valid=1 from the next cycle. Divider is not touched.
  - Head right!=0: load div_left/div_right, set div_go=1, go to ISSUE.
- ISSUE: lasts exactly one cycle, with div_go=1. Next edge: div_go=0, go to WAIT.
- div_left and div_right hold stable from ISSUE until the next launch.
- WAIT: on an edge with div_done=1, capture div_quotient, div_remainder, the stored tag and out_div_by_zero=0 into the output registers. Set out_valid=1 and return to IDLE.
  - No timeout.
  - div_done in IDLE or ISSUE is ignored.
- Output register: holds all fields stable while out_valid && !out_ready. Clears out_valid on the handshake edge.
- The next launch may occur no earlier than the cycle after out_valid drops, so at most one result is outstanding and results stay strictly in request order.
- Dividend 0 with divisor nonzero goes through the divider, which completes early; the result is 0/0.
- Latency with FIFO empty and output free:
  - Request accepted at edge T; popped at edge T+1; div_go high during cycle T+1.
  - out_valid rises on the edge after div_done is sampled.
  - Bypass path: out_valid rises at edge T+1.
- Reset mid-operation clears everything, including in-flight and queued requests. The top level must reset the divider in the same cycle. A stale div_done after reset is ignored because the FSM is IDLE.

Test Plan:
- WIDTH=4: push (13,3,tag=1), out_ready=1 -> div_go high exactly 1 cycle with div_left=13, div_right=3 -> out quotient=4, remainder=1, tag=1, div_by_zero=0.
- Push (7,0,tag=2) -> no div_go, out_valid at T+1 with quotient=15, remainder=7, div_by_zero=1.
- Push (0,5) -> quotient=0, remainder=0 via divider early done; then (15,1) -> quotient=15, remainder=0. Results arrive in order.
- out_ready=0, push 5 requests (9/2, 8/0, 6/4, 3/3, 14/5) -> first result held stable, 4 requests queued, in_ready=0 on full. Release out_ready -> results (4,1), (15,8), (1,2), (1,0), (2,4) in order.
- Assert reset=0 during WAIT, then release -> all outputs 0, busy=0, stale div_done ignored. A fresh request 10/3 -> quotient=3, remainder=1.
- Random back-to-back requests with random out_ready, checked against a / and % golden model (divisor 0 -> all-ones quotient, remainder = dividend).
